i2s_tx_serializer: RTL and testbench

I2S_TX_SERIALIZER -- requirements
Module: i2s_tx_serializer

---
 rtl/i2s_tx_serializer_if.sv | 13 +
 rtl/i2s_tx_serializer.sv | 134 +++++++++++++
 tb/tb_i2s_tx_serializer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_serializer_if.sv
// Stereo-frame stream into the I2S transmit serializer.
//   s_tdata  : one stereo frame, left in [31:0], right in [63:32]
//   s_tvalid : frame valid (source to serializer)
//   s_tready : frame accepted when s_tvalid and s_tready are both high
// The master modport is the frame source; the slave modport is the serializer.
interface i2s_tx_serializer_if;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;

  modport master (output s_tdata, output s_tvalid, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, output s_tready);
endinterface

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: buffers stereo frames in a small FIFO and shifts
// them out MSB first on sdata, one bclk after each lrck transition.
// Ports:
//   mclki      : master clock; bclk and lrck are generated in this domain
//   rst_n      : asynchronous active-low reset
//   enable     : run enable; when low, output is silenced and the FIFO is frozen
//   bclk, lrck : bit clock and word clock (lrck 0 = left slot, 1 = right slot)
//   word_width : bits per slot, 16 or 32; other values are ignored
//   s_axis     : stereo-frame stream (slave side)
//   sdata      : serial data, updated only on bclk falling edges
//   underrun   : one-cycle pulse when a left slot starts with the FIFO empty
// FIFO_DEPTH must be a power of two and at least 2.
module i2s_tx_serializer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                mclki,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                bclk,
  input  logic                lrck,
  input  logic [5:0]          word_width,
  i2s_tx_serializer_if.slave  s_axis,
  output logic                sdata,
  output logic                underrun
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic             bclk_q;
  logic             lrck_prev;
  logic             armed;      // a left slot has started since the last enable
  logic [5:0]       ww_r;
  logic [31:0]      shreg;
  logic [31:0]      frame_r;    // right half of the frame in flight
  logic [63:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic        fall_c;
  logic        chg_c;
  logic        lstart_c;
  logic        rstart_c;
  logic        ww_legal_c;
  logic [5:0]  ww_next_c;
  logic        push_c;
  logic        pop_c;
  logic        urun_c;
  logic [63:0] head_c;

  // MSB-align a sample in the 32-bit shift register for the given slot width
  function automatic logic [31:0] msb_align(input logic [31:0] word, input logic [5:0] ww);
    return (ww == 6'd16) ? {word[15:0], 16'h0000} : word;
  endfunction

  // Edge and slot-start detection
  assign fall_c     = bclk_q & ~bclk;
  assign chg_c      = fall_c & (lrck != lrck_prev);
  assign lstart_c   = chg_c & ~lrck;
  assign rstart_c   = chg_c & lrck;

  // A new width takes effect on the left slot where it is latched
  assign ww_legal_c = (word_width == 6'd16) || (word_width == 6'd32);
  assign ww_next_c  = ww_legal_c ? word_width : ww_r;

  // FIFO handshake; ready is held low while reset is asserted
  assign s_axis.s_tready = rst_n & enable & (count != FULL_CNT);
  assign push_c          = s_axis.s_tvalid & s_axis.s_tready;
  assign pop_c           = enable & lstart_c & (count != '0);
  assign urun_c          = enable & lstart_c & (count == '0);
  assign head_c          = mem[rd_ptr];

  // FIFO storage, no reset: contents are don't-care until written
  always_ff @(posedge mclki) begin
    if (push_c) mem[wr_ptr] <= s_axis.s_tdata;
  end

  // Edge tracking, FIFO pointers and the serializer datapath
  always_ff @(posedge mclki or negedge rst_n) begin
    if (!rst_n) begin
      bclk_q    <= 1'b0;
      lrck_prev <= 1'b0;
      armed     <= 1'b0;
      ww_r      <= 6'd32;
      shreg     <= '0;
      frame_r   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      sdata     <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      bclk_q   <= bclk;
      if (fall_c) lrck_prev <= lrck;
      underrun <= urun_c;

      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (!enable) begin
        sdata <= 1'b0;
        shreg <= '0;
        armed <= 1'b0;
      end else begin
        // sdata lags the load by one fall, giving the I2S one-bclk delay
        if (fall_c) sdata <= shreg[31];
        if (lstart_c) begin
          ww_r  <= ww_next_c;
          armed <= 1'b1;
          if (pop_c) begin
            frame_r <= head_c[63:32];
            shreg   <= msb_align(head_c[31:0], ww_next_c);
          end else begin
            // Underrun: silence both slots of this frame
            frame_r <= '0;
            shreg   <= '0;
          end
        end else if (rstart_c) begin
          shreg <= armed ? msb_align(frame_r, ww_r) : '0;
        end else if (fall_c) begin
          shreg <= {shreg[30:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: a bclk/lrck divider (bclk_factor=1),
// a frame-queue scoreboard filled on accepted pushes and drained at left-slot
// starts, and a monitor that rebuilds each slot word from sdata.
module tb_i2s_tx_serializer;

  localparam int unsigned DEPTH = 4;

  logic       mclki = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       bclk = 1'b0;
  logic       lrck = 1'b0;
  logic [5:0] word_width;
  logic       sdata;
  logic       underrun;

  i2s_tx_serializer_if s_if ();

  i2s_tx_serializer #(.FIFO_DEPTH(DEPTH)) dut (
    .mclki      (mclki),
    .rst_n      (rst_n),
    .enable     (enable),
    .bclk       (bclk),
    .lrck       (lrck),
    .word_width (word_width),
    .s_axis     (s_if),
    .sdata      (sdata),
    .underrun   (underrun)
  );

  always #5 mclki = ~mclki;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bclk toggles every mclki; lrck flips with the bclk fall ending each slot
  bit div_run        = 1'b0;
  int slot_bits      = 32;
  int slot_bits_next = 32;
  int bit_cnt        = 0;

  always @(negedge mclki) begin
    if (div_run) begin
      bclk = ~bclk;
      if (!bclk) begin
        bit_cnt++;
        if (bit_cnt == slot_bits) begin
          bit_cnt = 0;
          lrck = ~lrck;
          if (!lrck) slot_bits = slot_bits_next;
        end
      end
    end
  end

  // Scoreboard and slot monitor
  logic [63:0] model_q[$];
  logic [63:0] cur_frame;
  logic [31:0] acc;
  logic [31:0] exp_word;
  logic [5:0]  m_ww;
  bit          m_bclk_q, m_lrck_prev, m_armed, win_valid;
  bit          m_fall, m_chg, m_urun;
  int          n_lstart     = 0;
  int          n_exp_urun   = 0;
  int          n_seen_urun  = 0;

  function automatic logic [31:0] slot_exp(input logic [31:0] s, input logic [5:0] ww);
    return (ww == 6'd16) ? {16'h0000, s[15:0]} : s;
  endfunction

  always @(posedge mclki) begin
    #1;
    if (!rst_n) begin
      m_bclk_q    = 1'b0;
      m_lrck_prev = 1'b0;
      m_armed     = 1'b0;
      win_valid   = 1'b0;
      m_ww        = 6'd32;
      cur_frame   = '0;
      acc         = '0;
      model_q.delete();
    end else begin
      m_fall   = m_bclk_q && !bclk;
      m_bclk_q = bclk;
      m_urun   = 1'b0;
      if (!enable) begin
        m_armed   = 1'b0;
        win_valid = 1'b0;
      end
      if (m_fall) begin
        m_chg       = (lrck != m_lrck_prev);
        m_lrck_prev = lrck;
        acc         = {acc[30:0], sdata};
        if (!enable) chk("sdata_disabled", 64'(sdata), 64'd0);
        if (m_chg) begin
          if (win_valid) chk(m_lrck_prev ? "slot_left" : "slot_right", 64'(acc), 64'(exp_word));
          acc       = '0;
          win_valid = 1'b0;
          if (enable) begin
            if (!lrck) begin
              n_lstart++;
              if (word_width == 6'd16 || word_width == 6'd32) m_ww = word_width;
              if (model_q.size() > 0) begin
                cur_frame = model_q.pop_front();
              end else begin
                cur_frame = '0;
                m_urun    = 1'b1;
                n_exp_urun++;
              end
              m_armed   = 1'b1;
              exp_word  = slot_exp(cur_frame[31:0], m_ww);
              win_valid = 1'b1;
            end else begin
              exp_word  = m_armed ? slot_exp(cur_frame[63:32], m_ww) : 32'h0;
              win_valid = 1'b1;
            end
          end
        end
      end
      if (underrun) n_seen_urun++;
      chk("underrun", 64'(underrun), 64'(m_urun));
    end
  end

  // Offer a frame from a negedge until accepted; returns at a negedge
  task automatic push_frame(input logic [63:0] d);
    bit ok = 1'b0;
    bit rdy;
    s_if.s_tdata  = d;
    s_if.s_tvalid = 1'b1;
    for (int t = 0; t < 400 && !ok; t++) begin
      #4;
      rdy = s_if.s_tready;
      chk("s_tready", 64'(rdy), 64'(enable && (model_q.size() != DEPTH)));
      @(posedge mclki);
      #2;
      if (rdy) begin
        model_q.push_back(d);
        ok = 1'b1;
      end
      @(negedge mclki);
    end
    if (!ok) begin
      n_assert++;
      n_fail++;
      $error("FAIL push_timeout: observed not accepted expected accepted");
    end
  endtask

  task automatic idle();
    s_if.s_tvalid = 1'b0;
  endtask

  task automatic wait_size(input int n);
    int cyc = 0;
    while (model_q.size() > n && cyc < 3000) begin
      @(negedge mclki);
      cyc++;
    end
    n_assert++;
    if (model_q.size() > n) begin
      n_fail++;
      $error("FAIL drain_timeout: observed %0d queued expected %0d", model_q.size(), n);
    end
  endtask

  task automatic wait_lstarts(input int n);
    int target = n_lstart + n;
    int cyc    = 0;
    while (n_lstart < target && cyc < 3000) begin
      @(negedge mclki);
      cyc++;
    end
    n_assert++;
    if (n_lstart < target) begin
      n_fail++;
      $error("FAIL lstart_timeout: observed %0d expected %0d", n_lstart, target);
    end
  endtask

  // Stop at a posedge from which the next negedge produces an lstart
  task automatic wait_pre_lstart();
    int cyc = 0;
    bit hit = 1'b0;
    while (!hit && cyc < 3000) begin
      @(posedge mclki);
      #3;
      hit = bclk && lrck && (bit_cnt == slot_bits - 1);
      cyc++;
    end
    n_assert++;
    if (!hit) begin
      n_fail++;
      $error("FAIL pre_lstart_timeout: observed none expected slot end");
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b1;
    word_width    = 6'd32;
    s_if.s_tdata  = '0;
    s_if.s_tvalid = 1'b0;
    div_run       = 1'b1;

    // Reset state with enable high
    repeat (3) @(negedge mclki);
    #1;
    chk("reset_sdata",    64'(sdata),         64'd0);
    chk("reset_underrun", 64'(underrun),      64'd0);
    chk("reset_tready",   64'(s_if.s_tready), 64'd0);
    @(negedge mclki);
    rst_n = 1'b1;

    // 32-bit frames, including the L=80000001 / R=00000003 pattern
    push_frame({32'h0000_0003, 32'h8000_0001});
    push_frame({32'h1234_5678, 32'hF0F0_0F0F});
    push_frame({32'hFFFF_FFFF, 32'h0000_0000});
    idle();
    wait_size(0);
    wait_lstarts(2);

    // Push landing on an lstart with the FIFO empty: underrun, frame kept
    wait_pre_lstart();
    @(negedge mclki);
    push_frame({32'hA5A5_0001, 32'h8000_5A5A});
    idle();
    wait_lstarts(2);

    // Width change mid-left-slot: current frame 32-bit, next frames 16-bit
    push_frame({32'hCAFE_0001, 32'h8000_00FF});
    idle();
    wait_size(0);
    repeat (10) @(negedge mclki);
    word_width     = 6'd16;
    slot_bits_next = 16;
    push_frame({32'h0000_5A5A, 32'h0000_A5A5});
    push_frame({32'hBEEF_8001, 32'hDEAD_7FFE});
    idle();
    wait_size(0);
    repeat (6) @(negedge mclki);
    word_width = 6'd20;
    push_frame({32'h1234_C3C3, 32'h5678_3C3C});
    idle();
    wait_size(0);
    wait_lstarts(1);

    // Enable dropped mid-frame: silence, FIFO retained, restart at next lstart
    push_frame({32'h0000_1111, 32'h0000_2222});
    push_frame({32'h0000_3333, 32'h0000_4444});
    push_frame({32'h0000_5555, 32'h0000_6666});
    idle();
    wait_size(2);
    repeat (8) @(negedge mclki);
    enable = 1'b0;
    repeat (50) @(negedge mclki);
    #1;
    chk("disabled_sdata",  64'(sdata),         64'd0);
    chk("disabled_tready", 64'(s_if.s_tready), 64'd0);
    @(negedge mclki);
    enable = 1'b1;
    wait_size(0);
    wait_lstarts(1);

    // FIFO full: five back-to-back pushes right after an lstart
    wait_lstarts(1);
    for (int i = 0; i < 5; i++) push_frame({$urandom(), $urandom()});
    idle();
    wait_size(0);
    wait_lstarts(1);

    // Reset asserted mid-right-slot
    push_frame({32'h0000_7777, 32'h0000_8888});
    idle();
    wait_size(0);
    while (!lrck) @(negedge mclki);
    repeat (5) @(negedge mclki);
    slot_bits_next = 32;
    word_width     = 6'd32;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_sdata",    64'(sdata),         64'd0);
    chk("midreset_tready",   64'(s_if.s_tready), 64'd0);
    chk("midreset_underrun", 64'(underrun),      64'd0);
    repeat (3) @(negedge mclki);
    rst_n = 1'b1;
    push_frame({32'h0F0F_F0F0, 32'h8000_0001});
    idle();
    wait_size(0);
    wait_lstarts(2);

    #1;
    chk("tready_idle", 64'(s_if.s_tready), 64'd1);
    chk("urun_total",  64'(n_seen_urun),   64'(n_exp_urun));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
